// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access controller with lane steering, wait-state stall, misalignment and timeout abort
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] MEM_ALU_RESULT,
  input  logic [31:0] MEM_RS2_DATA,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  MEM_FUNC3,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  output logic        DMEM_RE,
  output logic        DMEM_WE,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_READY,
  output logic [31:0] MEM_DATA_OUT,
  output logic        MEM_STALL,
  output logic        MEM_MISALIGNED,
  output logic        MEM_FAULT
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] l_addr, l_wdata;
  logic [3:0]  l_be;
  logic        l_re, l_we;
  logic [1:0]  l_off;
  logic [1:0]  off;
  logic        req, mis, go, in_wait, timeout, en, re_in;
  logic [3:0]  be_in;
  logic [31:0] wd_in, addr_in;
  logic [1:0]  off_sel;
  logic        re_sel;
  logic        unused_f3;
  assign unused_f3 = MEM_FUNC3[2];
  assign off     = MEM_ALU_RESULT[1:0];
  assign req     = MEM_READ | MEM_WRITE;
  // func3[1] selects word size, func3[0] halfword; bit 2 only carries signedness
  assign mis     = req && (MEM_FUNC3[1] ? (off != 2'b00) : (MEM_FUNC3[0] & off[0]));
  assign go      = req && !mis;
  assign re_in   = MEM_READ & ~MEM_WRITE;
  assign addr_in = {MEM_ALU_RESULT[31:2], 2'b00};
  assign in_wait = (state == WAIT);
  assign timeout = in_wait && !DMEM_READY && (cnt == 8'(MAX_WAIT));
  always_comb begin
    be_in = !MEM_WRITE ? 4'hF
          : MEM_FUNC3[1] ? 4'hF
          : MEM_FUNC3[0] ? (off[1] ? 4'b1100 : 4'b0011)
          : 4'b0001 << off;
    wd_in = !MEM_WRITE ? 32'h0
          : MEM_FUNC3[1] ? MEM_RS2_DATA
          : MEM_FUNC3[0] ? {2{MEM_RS2_DATA[15:0]}}
          : {4{MEM_RS2_DATA[7:0]}};
  end
  // en: an access is presented to memory this cycle (never during reset or a timeout abort)
  assign en      = !RST && (in_wait ? !timeout : go);
  assign off_sel = in_wait ? l_off : off;
  assign re_sel  = in_wait ? l_re : re_in;
  always_comb begin
    DMEM_ADDR      = en ? (in_wait ? l_addr : addr_in) : 32'h0;
    DMEM_WDATA     = en ? (in_wait ? l_wdata : wd_in) : 32'h0;
    DMEM_BE        = en ? (in_wait ? l_be : be_in) : 4'h0;
    DMEM_RE        = en && re_sel;
    DMEM_WE        = en && (in_wait ? l_we : MEM_WRITE);
    MEM_STALL      = en && !DMEM_READY;
    MEM_DATA_OUT   = (en && DMEM_READY && re_sel) ? DMEM_RDATA >> {off_sel, 3'b000} : 32'h0;
    MEM_MISALIGNED = !RST && !in_wait && mis;
    MEM_FAULT      = !RST && timeout;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= 8'h0;
      l_addr  <= 32'h0;
      l_wdata <= 32'h0;
      l_be    <= 4'h0;
      l_re    <= 1'b0;
      l_we    <= 1'b0;
      l_off   <= 2'b00;
    end else if (state == IDLE) begin
      if (go && !DMEM_READY) begin
        state   <= WAIT;
        cnt     <= 8'h1;
        l_addr  <= addr_in;
        l_wdata <= wd_in;
        l_be    <= be_in;
        l_re    <= re_in;
        l_we    <= MEM_WRITE;
        l_off   <= off;
      end
    end else if (DMEM_READY || timeout) begin
      state <= IDLE;
    end else begin
      cnt <= cnt + 8'h1;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with directed cases and randomized traffic
module tb_mem_access_unit;
  localparam int MW = 4;
  logic        CLK = 1'b0, RST = 1'b1;
  logic [31:0] MEM_ALU_RESULT = '0, MEM_RS2_DATA = '0, DMEM_RDATA = '0;
  logic        MEM_READ = 1'b0, MEM_WRITE = 1'b0, DMEM_READY = 1'b0;
  logic [2:0]  MEM_FUNC3 = '0;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, MEM_DATA_OUT;
  logic [3:0]  DMEM_BE;
  logic        DMEM_RE, DMEM_WE, MEM_STALL, MEM_MISALIGNED, MEM_FAULT;

  mem_access_unit #(.MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST(RST), .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_RS2_DATA(MEM_RS2_DATA),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_FUNC3(MEM_FUNC3),
    .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE),
    .DMEM_RE(DMEM_RE), .DMEM_WE(DMEM_WE), .DMEM_RDATA(DMEM_RDATA), .DMEM_READY(DMEM_READY),
    .MEM_DATA_OUT(MEM_DATA_OUT), .MEM_STALL(MEM_STALL), .MEM_MISALIGNED(MEM_MISALIGNED),
    .MEM_FAULT(MEM_FAULT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          kind;
    logic [31:0] addr, wdata, data;
    logic [3:0]  be;
    logic        re, we;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // one access: READY rises d cycles after issue; inputs turn to garbage once the access is latched
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] rs2, input logic [31:0] rdata, input int d);
    exp_t e;
    int   sz, last, off;
    bit   req, mis, flt;
    sz   = f3[1] ? 4 : f3[0] ? 2 : 1;
    off  = int'(a[1:0]);
    req  = rd | wr;
    mis  = req && (off % sz != 0);
    flt  = req && !mis && d > MW;
    last = (!req || mis) ? 0 : flt ? MW : d;
    e.kind  = mis ? 1 : flt ? 2 : 0;
    e.addr  = a & ~32'h3;
    e.we    = wr;
    e.re    = rd && !wr;
    e.be    = !wr ? 4'hF : 4'(((1 << sz) - 1) << off);
    e.wdata = !wr ? 32'h0 : sz == 4 ? rs2 : sz == 2 ? {2{rs2[15:0]}} : {4{rs2[7:0]}};
    e.data  = (e.kind == 0 && e.re) ? rdata >> (8 * off) : 32'h0;
    if (req) q.push_back(e);
    DMEM_RDATA = rdata;
    for (int c = 0; c <= last; c++) begin
      if (c == 0) begin
        MEM_READ = rd; MEM_WRITE = wr; MEM_FUNC3 = f3; MEM_ALU_RESULT = a; MEM_RS2_DATA = rs2;
      end else begin
        MEM_READ = 1'($urandom); MEM_WRITE = 1'($urandom); MEM_FUNC3 = 3'($urandom);
        MEM_ALU_RESULT = $urandom; MEM_RS2_DATA = $urandom;
      end
      DMEM_READY = (c == d);
      #1;
      chk("stall", MEM_STALL, 32'(req && !mis && c < last));
      if (req && !mis && !(flt && c == last)) chk("addr_hold", DMEM_ADDR, e.addr);
      if (!req) chk("idle_outputs", {DMEM_RE, DMEM_WE, DMEM_BE, MEM_STALL}, 32'h0);
      @(posedge CLK); #1;
    end
  endtask

  exp_t m_e;
  int   m_k;
  logic m_done;
  always @(negedge CLK) begin
    if (!RST) begin
      m_done = (DMEM_RE | DMEM_WE) && DMEM_READY && !MEM_STALL;
      if (MEM_MISALIGNED || MEM_FAULT || m_done) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_response: got mis=%0b fault=%0b done=%0b expected none",
                   MEM_MISALIGNED, MEM_FAULT, m_done);
        end else begin
          m_e = q.pop_front();
          m_k = MEM_FAULT ? 2 : MEM_MISALIGNED ? 1 : 0;
          chk("kind", m_k, m_e.kind);
          chk("exclusive", 32'(MEM_FAULT & MEM_MISALIGNED), 32'h0);
          chk("resp_stall", MEM_STALL, 32'h0);
          chk("data", MEM_DATA_OUT, m_e.data);
          if (m_e.kind == 0) begin
            chk("addr", DMEM_ADDR, m_e.addr);
            chk("be", DMEM_BE, m_e.be);
            chk("wdata", DMEM_WDATA, m_e.wdata);
            chk("re_we", {DMEM_RE, DMEM_WE}, {m_e.re, m_e.we});
          end else begin
            chk("abort_strobes", {DMEM_RE, DMEM_WE}, 32'h0);
          end
        end
      end
    end
  end

  initial begin
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a;
    int          op;
    MEM_READ = 1'b1; MEM_ALU_RESULT = 32'h10; MEM_FUNC3 = 3'b010; DMEM_READY = 1'b1;
    DMEM_RDATA = 32'hFFFF_FFFF; MEM_RS2_DATA = 32'hFFFF_FFFF;
    #12;
    chk("rst_addr", DMEM_ADDR, 32'h0);
    chk("rst_wdata", DMEM_WDATA, 32'h0);
    chk("rst_strobes", {DMEM_RE, DMEM_WE, DMEM_BE}, 32'h0);
    chk("rst_flags", {MEM_STALL, MEM_MISALIGNED, MEM_FAULT}, 32'h0);
    chk("rst_data", MEM_DATA_OUT, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    issue(1, 0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 0);
    issue(1, 0, 3'b100, 32'h103, 32'h0, 32'hAABBCCDD, 0);
    issue(1, 0, 3'b001, 32'h102, 32'h0, 32'hAABBCCDD, 0);
    issue(0, 1, 3'b000, 32'h201, 32'h12345678, 32'h0, 0);
    issue(0, 1, 3'b001, 32'h202, 32'h12345678, 32'h0, 0);
    issue(1, 0, 3'b010, 32'h40, 32'h0, 32'h11223344, 3);
    issue(1, 0, 3'b010, 32'h41, 32'h0, 32'h0, 0);
    issue(1, 0, 3'b010, 32'h50, 32'h0, 32'h55667788, 9);
    issue(1, 1, 3'b010, 32'h60, 32'hDEADBEEF, 32'h99999999, 1);
    issue(0, 0, 3'b000, 32'h70, 32'h0, 32'h0, 0);
    MEM_READ = 1'b0; MEM_WRITE = 1'b1; MEM_FUNC3 = 3'b010; MEM_ALU_RESULT = 32'h80;
    MEM_RS2_DATA = 32'h0BADF00D; DMEM_READY = 1'b0;
    @(posedge CLK); #1;
    chk("wait_we", DMEM_WE, 32'h1);
    #2;
    RST = 1'b1;
    #1;
    chk("rst_we_drop", DMEM_WE, 32'h0);
    chk("rst_no_fault", MEM_FAULT, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0; MEM_WRITE = 1'b0;
    #1;
    chk("post_rst_idle", {MEM_STALL, DMEM_WE, DMEM_RE}, 32'h0);
    @(posedge CLK); #1;
    issue(1, 0, 3'b000, 32'h91, 32'h0, 32'h01020304, 0);
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      rd = (op == 1) || (op > 5);
      wr = (op >= 1) && (op <= 5);
      f3 = 3'($urandom_range(0, wr ? 2 : 4));
      if (f3 > 3'd2) f3 = f3 + 3'd1;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = f3[1] ? 2'b00 : f3[0] ? {a[1], 1'b0} : a[1:0];
      issue(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 6));
    end
    MEM_READ = 1'b0; MEM_WRITE = 1'b0; DMEM_READY = 1'b0;
    @(posedge CLK); #1;
    chk("queue_empty", q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
